// File: rtl/grid_pkg.sv
// Shared types and constants for the 12x12 board-status controller.
// Status/command encodings and the read-modify-write rule live here.
package grid_pkg;

    localparam int GRID_ROWS_DFLT    = 12;
    localparam int GRID_COLUMNS_DFLT = 12;

    localparam int COL_MSB = 7;
    localparam int COL_LSB = 4;
    localparam int ROW_MSB = 3;
    localparam int ROW_LSB = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_SHIP  = 2'b01,
        ST_MISS  = 2'b10,
        ST_HIT   = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_PLACE = 2'b01,
        CMD_SHOOT = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    // New cell value for PLACE/SHOOT; anything not listed keeps its old value.
    function automatic status_t apply_cmd(cmd_t cmd, status_t old);
        status_t nxt;
        nxt = old;
        case (cmd)
            CMD_PLACE: if (old == ST_EMPTY) nxt = ST_SHIP;
            CMD_SHOOT: begin
                if (old == ST_EMPTY)     nxt = ST_MISS;
                else if (old == ST_SHIP) nxt = ST_HIT;
            end
            default: nxt = old;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/grid_ctl_if.sv
// Requester handshake and VGA read bus of the board-status controller.
// master = game logic / VGA side, slave = grid_ctl.
interface grid_ctl_if;
    logic [7:0] vga_addr;
    logic [1:0] vga_status;
    logic [1:0] req;
    logic [1:0] cmd0;
    logic [1:0] cmd1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [1:0] ack;
    logic [1:0] result;
    logic       err;
    logic       busy;

    modport master (
        output vga_addr, req, cmd0, cmd1, addr0, addr1,
        input  vga_status, ack, result, err, busy
    );

    modport slave (
        input  vga_addr, req, cmd0, cmd1, addr0, addr1,
        output vga_status, ack, result, err, busy
    );
endinterface

// File: rtl/grid_ram.sv
// 256x2 board-status memory: port A is the VGA read port, port B the
// controller read/write port. Both reads are registered and see old data.
module grid_ram
    import grid_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic [7:0] a_addr,
    output status_t a_rdata,
    input  logic    b_we,
    input  logic [7:0] b_addr,
    input  status_t b_wdata,
    output status_t b_rdata
);

    status_t mem [0:255];
    status_t a_rdata_q;
    status_t b_rdata_q;

    always_ff @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_wdata;
    end

    // Only the output registers reset; array contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_q <= ST_EMPTY;
            b_rdata_q <= ST_EMPTY;
        end else begin
            a_rdata_q <= mem[a_addr];
            b_rdata_q <= mem[b_addr];
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/grid_ctl.sv
// Board-status controller: round-robin arbiter for two requesters, clear
// sweep and read-modify-write sequencing around grid_ram.
module grid_ctl
    import grid_pkg::*;
#(
    parameter int GRID_ROWS      = GRID_ROWS_DFLT,
    parameter int GRID_COLUMNS   = GRID_COLUMNS_DFLT,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    grid_ctl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_MODIFY,
        S_RESP
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t     state_q, state_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic       clr_by_req_q, clr_by_req_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       id_q, id_d;
    cmd_t       cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [1:0] ack_q, ack_d;
    status_t    result_q, result_d;
    logic       err_q, err_d;

    logic       gnt_id;
    cmd_t       gnt_cmd;
    logic [7:0] gnt_addr;
    status_t    new_st;

    logic       ram_we;
    logic [7:0] ram_addr;
    status_t    ram_wdata;
    status_t    ram_rdata;
    status_t    vga_rdata;

    function automatic logic in_grid(logic [7:0] a);
        return (int'(a[COL_MSB:COL_LSB]) < GRID_COLUMNS) &&
               (int'(a[ROW_MSB:ROW_LSB]) < GRID_ROWS);
    endfunction

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_by_req_d = clr_by_req_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        ack_d        = 2'b00;
        result_d     = result_q;
        err_d        = err_q;
        gnt_id       = 1'b0;
        gnt_cmd      = CMD_NOP;
        gnt_addr     = 8'h00;
        new_st       = apply_cmd(cmd_q, ram_rdata);
        ram_we       = 1'b0;
        ram_addr     = addr_q;
        ram_wdata    = ST_EMPTY;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt_id   = (bus.req == 2'b11) ? rr_ptr_q : bus.req[1];
                    gnt_cmd  = gnt_id ? cmd_t'(bus.cmd1) : cmd_t'(bus.cmd0);
                    gnt_addr = gnt_id ? bus.addr1 : bus.addr0;
                    id_d     = gnt_id;
                    cmd_d    = gnt_cmd;
                    addr_d   = gnt_addr;
                    rr_ptr_d = ~gnt_id;
                    if (gnt_cmd == CMD_CLEAR) begin
                        state_d      = S_CLEAR;
                        clr_cnt_d    = 8'h00;
                        clr_by_req_d = 1'b1;
                    end else if ((gnt_cmd == CMD_PLACE || gnt_cmd == CMD_SHOOT) &&
                                 in_grid(gnt_addr)) begin
                        state_d = S_READ;
                    end else begin
                        // NOP or off-board target: answer straight away, no write
                        state_d  = S_RESP;
                        ack_d    = gnt_id ? 2'b10 : 2'b01;
                        result_d = ST_EMPTY;
                        err_d    = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) begin
                    clr_by_req_d = 1'b0;
                    if (clr_by_req_q) begin
                        state_d  = S_RESP;
                        ack_d    = id_q ? 2'b10 : 2'b01;
                        result_d = ST_EMPTY;
                        err_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_READ: begin
                state_d = S_MODIFY;
            end
            S_MODIFY: begin
                ram_we    = (new_st != ram_rdata);
                ram_wdata = new_st;
                result_d  = new_st;
                err_d     = 1'b0;
                ack_d     = id_q ? 2'b10 : 2'b01;
                state_d   = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            clr_cnt_q    <= 8'h00;
            clr_by_req_q <= 1'b0;
            rr_ptr_q     <= 1'b0;
            id_q         <= 1'b0;
            cmd_q        <= CMD_NOP;
            addr_q       <= 8'h00;
            ack_q        <= 2'b00;
            result_q     <= ST_EMPTY;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_by_req_q <= clr_by_req_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            ack_q        <= ack_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    grid_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (bus.vga_addr),
        .a_rdata (vga_rdata),
        .b_we    (ram_we),
        .b_addr  (ram_addr),
        .b_wdata (ram_wdata),
        .b_rdata (ram_rdata)
    );

    assign bus.vga_status = vga_rdata;
    assign bus.ack        = ack_q;
    assign bus.result     = result_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
